// File: rtl/fifo_serializer.sv
// Word-to-serial converter fed by an upstream FIFO.
// Pops one WIDTH-bit word, then shifts it out MSB first with each bit held for DIV
// ready cycles. Downstream backpressure (ser_ready=0) freezes the bit timer.
// Note: reset_n is synchronous and active-HIGH despite its name.
module fifo_serializer #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DIV   = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             enable,
  input  logic             fifo_empty,
  output logic             fifo_pop,
  input  logic [WIDTH-1:0] fifo_data,
  input  logic             ser_ready,
  output logic             ser_data,
  output logic             ser_valid,
  output logic             ser_first,
  output logic             ser_last,
  output logic             busy,
  output logic [15:0]      words_sent
);

  localparam int unsigned     BitW    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [BitW-1:0] LastBit = BitW'(WIDTH - 1);
  localparam logic [7:0]      LastDiv = 8'(DIV - 1);

  typedef enum logic [1:0] {StIdle, StPop, StCapture, StShift} state_e;

  state_e           state_q;
  logic [WIDTH-1:0] shift_q;
  logic [BitW-1:0]  bit_q;
  logic [7:0]       div_q;
  logic             fifo_pop_q;
  logic             ser_data_q;
  logic             ser_valid_q;
  logic             ser_first_q;
  logic             ser_last_q;
  logic             busy_q;
  logic [15:0]      words_q;

  logic [WIDTH-1:0] shift_adv;
  logic             fetch_ok;

  assign shift_adv = shift_q << 1;
  // A new word may be fetched only when allowed and the FIFO has data.
  assign fetch_ok  = enable && !fifo_empty;

  // FSM, counters, shift register and all registered outputs.
  always_ff @(posedge clk) begin
    if (reset_n) begin
      state_q     <= StIdle;
      shift_q     <= '0;
      bit_q       <= '0;
      div_q       <= '0;
      fifo_pop_q  <= 1'b0;
      ser_data_q  <= 1'b0;
      ser_valid_q <= 1'b0;
      ser_first_q <= 1'b0;
      ser_last_q  <= 1'b0;
      busy_q      <= 1'b0;
      words_q     <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (fetch_ok) begin
            state_q    <= StPop;
            fifo_pop_q <= 1'b1;
            busy_q     <= 1'b1;
          end
        end
        StPop: begin
          state_q    <= StCapture;
          fifo_pop_q <= 1'b0;
        end
        StCapture: begin
          // FIFO read data is valid now, one cycle after the pop.
          shift_q     <= fifo_data;
          bit_q       <= '0;
          div_q       <= '0;
          state_q     <= StShift;
          ser_valid_q <= 1'b1;
          ser_data_q  <= fifo_data[WIDTH-1];
          ser_first_q <= 1'b1;
          ser_last_q  <= (WIDTH == 1);
        end
        StShift: begin
          if (ser_ready) begin
            if (div_q == LastDiv) begin
              div_q <= '0;
              if (bit_q == LastBit) begin
                // Word complete: count it and decide whether to fetch the next one.
                words_q     <= words_q + 16'd1;
                bit_q       <= '0;
                shift_q     <= shift_adv;
                ser_valid_q <= 1'b0;
                ser_data_q  <= 1'b0;
                ser_first_q <= 1'b0;
                ser_last_q  <= 1'b0;
                if (fetch_ok) begin
                  state_q    <= StPop;
                  fifo_pop_q <= 1'b1;
                end else begin
                  state_q <= StIdle;
                  busy_q  <= 1'b0;
                end
              end else begin
                bit_q       <= bit_q + BitW'(1);
                shift_q     <= shift_adv;
                ser_data_q  <= shift_adv[WIDTH-1];
                ser_first_q <= 1'b0;
                ser_last_q  <= ((bit_q + BitW'(1)) == LastBit);
              end
            end else begin
              div_q <= div_q + 8'd1;
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign fifo_pop   = fifo_pop_q;
  assign ser_data   = ser_data_q;
  assign ser_valid  = ser_valid_q;
  assign ser_first  = ser_first_q;
  assign ser_last   = ser_last_q;
  assign busy       = busy_q;
  assign words_sent = words_q;

endmodule

// File: tb/tb_fifo_serializer.sv
// Bench for fifo_serializer: two instances (DIV=2 and DIV=1, WIDTH=8) share stimulus,
// each fed by its own queue-backed FIFO. A timing model checks every cycle; directed
// scenarios add hand-computed literal expectations.
module tb_fifo_serializer;

  localparam int W = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           reset_n;
  logic           enable;
  logic           ser_ready;
  logic           fifo_empty  [2];
  logic [W-1:0]   fifo_data   [2];
  logic           fifo_pop    [2];
  logic           ser_data    [2];
  logic           ser_valid   [2];
  logic           ser_first   [2];
  logic           ser_last    [2];
  logic           busy        [2];
  logic [15:0]    words_sent  [2];

  int n_checks = 0;
  int n_errors = 0;

  logic [W-1:0] q0[$];
  logic [W-1:0] q1[$];

  int a5_bits [8] = '{1, 0, 1, 0, 0, 1, 0, 1};

  fifo_serializer #(.WIDTH(W), .DIV(2)) u_div2 (
    .clk        (clk),
    .reset_n    (reset_n),
    .enable     (enable),
    .fifo_empty (fifo_empty[0]),
    .fifo_pop   (fifo_pop[0]),
    .fifo_data  (fifo_data[0]),
    .ser_ready  (ser_ready),
    .ser_data   (ser_data[0]),
    .ser_valid  (ser_valid[0]),
    .ser_first  (ser_first[0]),
    .ser_last   (ser_last[0]),
    .busy       (busy[0]),
    .words_sent (words_sent[0])
  );

  fifo_serializer #(.WIDTH(W), .DIV(1)) u_div1 (
    .clk        (clk),
    .reset_n    (reset_n),
    .enable     (enable),
    .fifo_empty (fifo_empty[1]),
    .fifo_pop   (fifo_pop[1]),
    .fifo_data  (fifo_data[1]),
    .ser_ready  (ser_ready),
    .ser_data   (ser_data[1]),
    .ser_valid  (ser_valid[1]),
    .ser_first  (ser_first[1]),
    .ser_last   (ser_last[1]),
    .busy       (busy[1]),
    .words_sent (words_sent[1])
  );

  function automatic int div_of(int k);
    return (k == 0) ? 2 : 1;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic sync_empty();
    fifo_empty[0] = (q0.size() == 0);
    fifo_empty[1] = (q1.size() == 0);
  endtask

  task automatic push(logic [W-1:0] w);
    q0.push_back(w);
    q1.push_back(w);
    sync_empty();
  endtask

  // Input drive point: just after the rising edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_pop(int k, output logic found);
    found = 1'b0;
    for (int i = 0; i < 200 && !found; i++) begin
      @(negedge clk);
      if (fifo_pop[k] === 1'b1) found = 1'b1;
    end
    chk($sformatf("div%0d pop seen", div_of(k)), found, 1);
  endtask

  task automatic wait_idle();
    logic done;
    done = 1'b0;
    for (int i = 0; i < 300 && !done; i++) begin
      @(negedge clk);
      if (busy[0] === 1'b0 && busy[1] === 1'b0 && q0.size() == 0 && q1.size() == 0)
        done = 1'b1;
    end
    chk("wait idle", done, 1);
  endtask

  // Upstream FIFO: a pop seen in cycle N presents the head word during cycle N+1.
  initial begin
    logic p0, p1;
    forever begin
      @(negedge clk);
      p0 = fifo_pop[0];
      p1 = fifo_pop[1];
      @(posedge clk);
      #1;
      if (p0 === 1'b1) fifo_data[0] = (q0.size() > 0) ? q0.pop_front() : '0;
      if (p1 === 1'b1) fifo_data[1] = (q1.size() > 0) ? q1.pop_front() : '0;
      sync_empty();
    end
  end

  // Reference model: fetch takes two cycles (pop, capture), then the word lasts W*DIV
  // ready cycles with bit index = elapsed_ready_cycles / DIV.
  initial begin
    int           phase [2];  // 0 idle, 1 pop, 2 capture, 3 shifting
    int           t     [2];
    logic [W-1:0] word  [2];
    logic [15:0]  words [2];
    logic         synced;
    int           idx;
    logic         e_valid;
    synced = 1'b0;
    for (int k = 0; k < 2; k++) begin
      phase[k] = 0;
      t[k]     = 0;
      word[k]  = '0;
      words[k] = '0;
    end
    forever begin
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        if (synced) begin
          e_valid = (phase[k] == 3);
          idx     = t[k] / div_of(k);
          chk($sformatf("div%0d fifo_pop", div_of(k)), fifo_pop[k], phase[k] == 1);
          chk($sformatf("div%0d busy", div_of(k)), busy[k], phase[k] != 0);
          chk($sformatf("div%0d ser_valid", div_of(k)), ser_valid[k], e_valid);
          chk($sformatf("div%0d ser_data", div_of(k)), ser_data[k],
              e_valid ? word[k][W-1-idx] : 1'b0);
          chk($sformatf("div%0d ser_first", div_of(k)), ser_first[k], e_valid && idx == 0);
          chk($sformatf("div%0d ser_last", div_of(k)), ser_last[k], e_valid && idx == W-1);
          chk($sformatf("div%0d words_sent", div_of(k)), words_sent[k], words[k]);
        end
        if (reset_n === 1'b1) begin
          phase[k] = 0;
          t[k]     = 0;
          words[k] = '0;
        end else begin
          case (phase[k])
            0: if (enable && !fifo_empty[k]) phase[k] = 1;
            1: phase[k] = 2;
            2: begin
              word[k]  = fifo_data[k];
              t[k]     = 0;
              phase[k] = 3;
            end
            default: begin
              if (ser_ready) begin
                t[k]++;
                if (t[k] == W * div_of(k)) begin
                  words[k]++;
                  phase[k] = (enable && !fifo_empty[k]) ? 1 : 0;
                end
              end
            end
          endcase
        end
      end
      if (reset_n === 1'b1) synced = 1'b1;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic found;
    int   vcount;
    reset_n       = 1'b1;
    enable        = 1'b0;
    ser_ready     = 1'b1;
    fifo_data[0]  = '0;
    fifo_data[1]  = '0;
    sync_empty();
    repeat (3) cyc();
    reset_n = 1'b0;
    @(negedge clk);
    chk("reset fifo_pop", fifo_pop[0], 0);
    chk("reset ser_valid", ser_valid[0], 0);
    chk("reset ser_data", ser_data[0], 0);
    chk("reset busy", busy[0], 0);
    chk("reset words_sent", words_sent[0], 0);

    // Reset during bit 4 abandons the word; words_sent stays at its pre-word 0.
    cyc();
    push(8'hFF);
    enable = 1'b1;
    wait_pop(0, found);
    for (int c = 1; c <= 11; c++) begin
      cyc();
      if (c == 10) reset_n = 1'b1;
      if (c == 11) reset_n = 1'b0;
      @(negedge clk);
      if (c == 10) begin
        chk("rst mid valid", ser_valid[0], 1);
        chk("rst mid data", ser_data[0], 1);
      end
      if (c == 11) begin
        chk("rst after pop", fifo_pop[0], 0);
        chk("rst after valid", ser_valid[0], 0);
        chk("rst after data", ser_data[0], 0);
        chk("rst after first", ser_first[0], 0);
        chk("rst after last", ser_last[0], 0);
        chk("rst after busy", busy[0], 0);
        chk("rst after words", words_sent[0], 0);
      end
    end
    wait_idle();

    // Single word 8'hA5, DIV=2.
    cyc();
    push(8'hA5);
    wait_pop(0, found);
    for (int c = 1; c <= 18; c++) begin
      cyc();
      @(negedge clk);
      chk("a5 valid", ser_valid[0], c >= 2 && c <= 17);
      if (c >= 2 && c <= 17) chk("a5 data", ser_data[0], a5_bits[(c - 2) / 2]);
      chk("a5 first", ser_first[0], c == 2 || c == 3);
      chk("a5 last", ser_last[0], c == 16 || c == 17);
      chk("a5 no pop", fifo_pop[0], 0);
    end
    chk("a5 words_sent", words_sent[0], 1);
    wait_idle();

    // Back-to-back 8'h01, 8'h80 on the DIV=1 instance.
    cyc();
    push(8'h01);
    push(8'h80);
    wait_pop(1, found);
    for (int c = 1; c <= 20; c++) begin
      cyc();
      @(negedge clk);
      chk("b2b valid", ser_valid[1], (c >= 2 && c <= 9) || (c >= 12 && c <= 19));
      chk("b2b pop", fifo_pop[1], c == 10);
      chk("b2b data", ser_data[1], c == 9 || c == 12);
    end
    chk("b2b words_sent", words_sent[1], 3);
    chk("b2b busy end", busy[1], 0);
    wait_idle();

    // 8'h96 with a 5-cycle stall during bit 3 (DIV=2 instance).
    cyc();
    push(8'h96);
    wait_pop(0, found);
    vcount = 0;
    for (int c = 1; c <= 24; c++) begin
      cyc();
      ser_ready = !(c >= 8 && c <= 12);
      @(negedge clk);
      if (ser_valid[0] === 1'b1) vcount++;
      if (c == 12) chk("stall hold data", ser_data[0], 1);
      if (c == 14) chk("stall bit3 end", ser_data[0], 1);
      if (c == 15) chk("stall bit4", ser_data[0], 0);
    end
    chk("stall word cycles", vcount, 21);
    chk("stall words_sent", words_sent[0], 4);
    wait_idle();

    // Empty FIFO with enable high: nothing happens.
    for (int c = 1; c <= 20; c++) begin
      cyc();
      @(negedge clk);
      chk("empty pop", fifo_pop[0], 0);
      chk("empty busy", busy[0], 0);
      chk("empty valid", ser_valid[0], 0);
    end

    // Enable dropped mid-word with the FIFO non-empty, then raised again.
    cyc();
    push(8'h3C);
    push(8'h69);
    wait_pop(0, found);
    for (int c = 1; c <= 26; c++) begin
      cyc();
      if (c == 6)  enable = 1'b0;
      if (c == 23) enable = 1'b1;
      @(negedge clk);
      if (c == 17) chk("en-drop last bit", ser_last[0], 1);
      if (c >= 18 && c <= 23) begin
        chk("en-drop no pop", fifo_pop[0], 0);
        chk("en-drop idle", busy[0], 0);
      end
      if (c == 24) chk("en-raise pop", fifo_pop[0], 1);
    end
    wait_idle();
    chk("final words_sent", words_sent[0], 6);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
